// File: rtl/ram_loader_if.sv
// Byte-stream, control and RAM write-port signals of the boot loader.
// master: upstream byte source / host; slave: the loader itself.
interface ram_loader_if;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        ram_load_o;
  logic [14:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_o;

  modport master (
    output start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, ram_load_o, ram_addr_o, ram_data_o,
    input  busy_o, done_o, err_o, words_o
  );

  modport slave (
    input  start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, ram_load_o, ram_addr_o, ram_data_o,
    output busy_o, done_o, err_o, words_o
  );
endinterface

// File: rtl/ram_loader.sv
// Boot loader: parses a big-endian framed byte stream (LEN, LEN words, SUM)
// and writes the words sequentially into the data RAM, reporting done/error.
module ram_loader #(
  parameter logic [14:0] BASE_ADDR      = 15'd0,
  parameter int unsigned MAX_WORDS      = 32768,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic         clk_i,
  input logic         reset_i,
  ram_loader_if.slave bus
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, SUM_HI, SUM_LO, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    hi_q, hi_nxt;
  logic [15:0]   len_q, len_nxt;
  logic [15:0]   sum_q, sum_nxt;
  logic [15:0]   words_nxt, data_nxt;
  logic [14:0]   addr_nxt;
  logic [TW-1:0] tmo_q, tmo_nxt;
  logic          accept;
  logic [15:0]   rx_word;

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_q;
    len_nxt   = len_q;
    sum_nxt   = sum_q;
    words_nxt = bus.words_o;
    addr_nxt  = bus.ram_addr_o;
    data_nxt  = bus.ram_data_o;
    tmo_nxt   = tmo_q;
    accept    = bus.byte_valid_i & bus.byte_ready_o;
    rx_word   = {hi_q, bus.byte_data_i};

    if (bus.byte_ready_o) begin
      tmo_nxt = accept ? '0 : tmo_q + TW'(1);
    end

    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start_i) begin
          state_nxt = LEN_HI;
          sum_nxt   = '0;
          words_nxt = '0;
          tmo_nxt   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          hi_nxt    = bus.byte_data_i;
          state_nxt = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_nxt = rx_word;
          if (32'(rx_word) > MAX_WORDS) state_nxt = ERR;
          else if (rx_word == 16'd0)    state_nxt = SUM_HI;
          else                          state_nxt = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          hi_nxt    = bus.byte_data_i;
          state_nxt = DAT_LO;
        end
      end
      DAT_LO: begin
        if (accept) begin
          data_nxt  = rx_word;
          addr_nxt  = BASE_ADDR + bus.words_o[14:0];
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        sum_nxt   = sum_q + bus.ram_data_o;
        words_nxt = bus.words_o + 16'd1;
        state_nxt = (words_nxt == len_q) ? SUM_HI : DAT_HI;
      end
      SUM_HI: begin
        if (accept) begin
          hi_nxt    = bus.byte_data_i;
          state_nxt = SUM_LO;
        end
      end
      SUM_LO: begin
        if (accept) state_nxt = (rx_word == sum_q) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase

    // Inter-byte stall limit; a zero limit disables the check
    if (TIMEOUT_CYCLES != 0 && bus.byte_ready_o && !accept &&
        32'(tmo_nxt) >= TIMEOUT_CYCLES) begin
      state_nxt = ERR;
    end
  end

  // State, datapath and registered outputs (decoded from the next state)
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state            <= IDLE;
      hi_q             <= '0;
      len_q            <= '0;
      sum_q            <= '0;
      tmo_q            <= '0;
      bus.byte_ready_o <= 1'b0;
      bus.ram_load_o   <= 1'b0;
      bus.ram_addr_o   <= BASE_ADDR;
      bus.ram_data_o   <= '0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.words_o      <= '0;
    end else begin
      state            <= state_nxt;
      hi_q             <= hi_nxt;
      len_q            <= len_nxt;
      sum_q            <= sum_nxt;
      tmo_q            <= tmo_nxt;
      bus.byte_ready_o <= state_nxt inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO};
      bus.ram_load_o   <= (state_nxt == WRITE);
      bus.ram_addr_o   <= addr_nxt;
      bus.ram_data_o   <= data_nxt;
      bus.busy_o       <= !(state_nxt inside {IDLE, DONE, ERR});
      bus.done_o       <= (state_nxt == DONE);
      bus.err_o        <= (state_nxt == ERR);
      bus.words_o      <= words_nxt;
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: fixed frame table, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_ram_loader;
  localparam int BASE = 32'h7FFF;

  logic clk;
  logic reset_i;
  ram_loader_if bus();

  ram_loader #(
    .BASE_ADDR(15'h7FFF), .MAX_WORDS(32768), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [30:0] wr_q[$];
  logic [30:0] exp_wr[$];
  logic [7:0]  frame_q[$];
  logic        m_done, m_err;
  int          m_words;

  // Capture every RAM write cycle as {addr, data}
  always @(negedge clk) if (bus.ram_load_o) wr_q.push_back({bus.ram_addr_o, bus.ram_data_o});

  typedef struct {
    logic [95:0] frame;
    int          n;
    logic        done;
    logic        err;
    int          words;
    int          nwr;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: derive writes and final status directly from the frame bytes
  task automatic model();
    int len;
    logic [15:0] s, w, t;
    exp_wr.delete();
    m_done = 1'b0; m_err = 1'b0; m_words = 0;
    len = int'({frame_q[0], frame_q[1]});
    if (len > 32768) begin
      m_err = 1'b1;
      return;
    end
    s = 16'd0;
    for (int i = 0; i < len; i++) begin
      w = {frame_q[2+2*i], frame_q[3+2*i]};
      s = s + w;
      exp_wr.push_back({15'((BASE + i) % 32768), w});
    end
    m_words = len;
    t = {frame_q[2+2*len], frame_q[3+2*len]};
    if (t == s) m_done = 1'b1;
    else        m_err  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (bus.byte_ready_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("accept_wait", 32'(bus.byte_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic run_frame(input int gap_max);
    model();
    wr_q.delete();
    start_pulse();
    foreach (frame_q[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(frame_q[i]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes();
    check("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      check("wr_addr", 32'(wr_q[i][30:16]), 32'(exp_wr[i][30:16]));
      check("wr_data", 32'(wr_q[i][15:0]),  32'(exp_wr[i][15:0]));
    end
  endtask

  task automatic check_idle_outs();
    check("busy_end",  32'(bus.busy_o),       32'd0);
    check("ready_end", 32'(bus.byte_ready_o), 32'd0);
  endtask

  initial begin
    int len;
    logic [15:0] s, w;

    vecs[0] = '{96'h0002_1234_ABCD_BE01, 8, 1'b1, 1'b0, 2, 2};
    vecs[1] = '{96'h0002_1234_ABCD_BE02, 8, 1'b0, 1'b1, 2, 2};
    vecs[2] = '{96'h0000_0000, 4, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{96'h8001, 2, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{96'h0003_0001_0002_FFFF_0002, 10, 1'b1, 1'b0, 3, 3};
    vecs[5] = '{96'h0000_0001, 4, 1'b0, 1'b1, 0, 0};
    vecs[6] = '{96'hFFFF, 2, 1'b0, 1'b1, 0, 0};

    reset_i = 1'b0;
    bus.start_i = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.byte_ready_o), 32'd0);
    check("rst_load",  32'(bus.ram_load_o),   32'd0);
    check("rst_addr",  32'(bus.ram_addr_o),   32'h7FFF);
    check("rst_data",  32'(bus.ram_data_o),   32'd0);
    check("rst_busy",  32'(bus.busy_o),       32'd0);
    check("rst_done",  32'(bus.done_o),       32'd0);
    check("rst_err",   32'(bus.err_o),        32'd0);
    check("rst_words", 32'(bus.words_o),      32'd0);
    reset_i = 1'b1;
    @(negedge clk);

    // Fixed frame table, back to back
    for (int v = 0; v < 7; v++) begin
      frame_q.delete();
      for (int i = 0; i < vecs[v].n; i++) frame_q.push_back(vecs[v].frame[8*(vecs[v].n-1-i) +: 8]);
      run_frame(v % 3);
      check("tab_done",  32'(bus.done_o),  32'(vecs[v].done));
      check("tab_err",   32'(bus.err_o),   32'(vecs[v].err));
      check("tab_words", 32'(bus.words_o), 32'(vecs[v].words));
      check("tab_nwr",   32'(wr_q.size()), 32'(vecs[v].nwr));
      check_idle_outs();
      check_writes();
    end

    // start together with a valid byte, start while busy, write latency
    wr_q.delete();
    bus.start_i = 1'b1;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i = 8'h00;
    #0 check("startvalid_ready0", 32'(bus.byte_ready_o), 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("startvalid_ready1", 32'(bus.byte_ready_o), 32'd1);
    check("startvalid_busy",   32'(bus.busy_o),       32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    start_pulse();
    send_byte(8'h12);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i = 8'h34;
    @(posedge clk);
    @(negedge clk);
    bus.byte_data_i = 8'h12;
    check("lat_load_hi",  32'(bus.ram_load_o),   32'd1);
    check("lat_ready_lo", 32'(bus.byte_ready_o), 32'd0);
    check("lat_addr",     32'(bus.ram_addr_o),   32'h7FFF);
    check("lat_data",     32'(bus.ram_data_o),   32'h1234);
    @(negedge clk);
    check("lat_load_lo",  32'(bus.ram_load_o),   32'd0);
    check("lat_ready_hi", 32'(bus.byte_ready_o), 32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    check("hand_done",  32'(bus.done_o),  32'd1);
    check("hand_words", 32'(bus.words_o), 32'd1);
    check("hand_nwr",   32'(wr_q.size()), 32'd1);

    // Stall inside a frame until the timeout fires
    wr_q.delete();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    repeat (15) @(negedge clk);
    check("tmo_err_early", 32'(bus.err_o),  32'd0);
    check("tmo_busy",      32'(bus.busy_o), 32'd1);
    @(negedge clk);
    check("tmo_err",   32'(bus.err_o),  32'd1);
    check("tmo_done",  32'(bus.done_o), 32'd0);
    check("tmo_nwr",   32'(wr_q.size()), 32'd0);
    check_idle_outs();

    // Random frames against the model
    for (int r = 0; r < 30; r++) begin
      frame_q.delete();
      if ($urandom_range(0, 7) == 0) begin
        len = 32769 + int'($urandom_range(0, 32766));
        frame_q.push_back(8'(len >> 8));
        frame_q.push_back(8'(len));
      end else begin
        len = int'($urandom_range(0, 6));
        frame_q.push_back(8'(len >> 8));
        frame_q.push_back(8'(len));
        s = 16'd0;
        for (int i = 0; i < len; i++) begin
          w = 16'($urandom);
          s = s + w;
          frame_q.push_back(w[15:8]);
          frame_q.push_back(w[7:0]);
        end
        if ($urandom_range(0, 3) == 0) s = s ^ (16'd1 << $urandom_range(0, 15));
        frame_q.push_back(s[15:8]);
        frame_q.push_back(s[7:0]);
      end
      run_frame(3);
      check("rnd_done",  32'(bus.done_o),  32'(m_done));
      check("rnd_err",   32'(bus.err_o),   32'(m_err));
      check("rnd_words", 32'(bus.words_o), 32'(m_words));
      check_idle_outs();
      check_writes();
    end

    // Reset in the middle of a frame right after a write
    wr_q.delete();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset_i = 1'b0;
    @(negedge clk);
    check("mrst_load",  32'(bus.ram_load_o),   32'd0);
    check("mrst_ready", 32'(bus.byte_ready_o), 32'd0);
    check("mrst_busy",  32'(bus.busy_o),       32'd0);
    check("mrst_done",  32'(bus.done_o),       32'd0);
    check("mrst_err",   32'(bus.err_o),        32'd0);
    check("mrst_words", 32'(bus.words_o),      32'd0);
    check("mrst_addr",  32'(bus.ram_addr_o),   32'h7FFF);
    check("mrst_data",  32'(bus.ram_data_o),   32'd0);
    reset_i = 1'b1;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i = 8'hCC;
    repeat (6) @(negedge clk);
    bus.byte_valid_i = 1'b0;
    check("mrst_idle_ready", 32'(bus.byte_ready_o), 32'd0);
    check("mrst_idle_busy",  32'(bus.busy_o),       32'd0);
    check("mrst_nwr",        32'(wr_q.size()),      32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
